// File: rtl/result_checker_pkg.sv
// Shared definitions for the result checker.
// Contents: Avalon register word offsets, CTRL/STATUS bit positions,
// error counter saturation value and the checker FSM state encoding.
package result_checker_pkg;

   localparam logic [2:0] REG_CTRL       = 3'd0;
   localparam logic [2:0] REG_START_ADDR = 3'd1;
   localparam logic [2:0] REG_COUNT      = 3'd2;
   localparam logic [2:0] REG_STATUS     = 3'd3;
   localparam logic [2:0] REG_ERR_COUNT  = 3'd4;
   localparam logic [2:0] REG_FIRST_ERR  = 3'd5;
   localparam logic [2:0] REG_LAST_ADDR  = 3'd6;
   localparam logic [2:0] REG_ID         = 3'd7;

   localparam int CTRL_START      = 0;
   localparam int CTRL_CLEAR      = 1;
   localparam int STAT_BUSY       = 0;
   localparam int STAT_DONE       = 1;
   localparam int STAT_ERR_SAT    = 2;
   localparam int FIRST_ERR_VALID = 31;

   localparam logic [31:0] ERR_SAT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } rc_state_e;

endpackage

// File: rtl/result_checker_if.sv
// Avalon-MM register bus between the HPS bridge and the result checker.
// Signals: read/write strobes, 3-bit word address, 32-bit write data and
// 32-bit registered read data (one-cycle latency).
// master: bus driver (HPS side / testbench); slave: the checker.
interface result_checker_if;

   logic        read;
   logic        write;
   logic [2:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output read, output write, output address, output writedata,
                   input readdata);
   modport slave  (input read, input write, input address, input writedata,
                   output readdata);

endinterface

// File: rtl/rc_valid_pipe.sv
// Delay line that tracks RAM reads in flight.
// Ports: clock, resetn (async, active low), flush (sync, drops all valids),
// in_valid/in_tag (read issued this cycle, its address),
// out_valid/out_tag (read whose data is on the RAM q ports now).
module rc_valid_pipe #(
   parameter int DEPTH = 2,
   parameter int TAG_W = 9
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   output logic [TAG_W-1:0] out_tag
);

   logic             valid_q [DEPTH];
   logic             valid_d [DEPTH];
   logic [TAG_W-1:0] tag_q   [DEPTH];
   logic [TAG_W-1:0] tag_d   [DEPTH];

   always_comb begin
      valid_d[0] = in_valid & ~flush;
      tag_d[0]   = in_tag;
      for (int i = 1; i < DEPTH; i++) begin
         valid_d[i] = valid_q[i-1] & ~flush;
         tag_d[i]   = tag_q[i-1];
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= valid_d[i];
            tag_q[i]   <= tag_d[i];
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/result_checker.sv
// Result checker: reads the product RAM and the expected-value RAM in
// lockstep over a programmable address window and counts mismatches.
// Ports: clock, resetn (async, active low), avs (Avalon-MM register slave),
// rd_addr_res/q_res (product RAM read port), rd_addr_exp/q_exp (expected
// RAM read port, same address), busy (check in progress).
//
// state    | meaning
// ST_IDLE  | no check armed, waiting for START
// ST_ISSUE | one RAM read address per cycle until COUNT issued
// ST_DRAIN | last reads still in flight, RD_LATENCY cycles
// ST_DONE  | results valid, done=1; START re-arms
module result_checker
   import result_checker_pkg::*;
#(
   parameter int ID         = 9,
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 128,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clock,
   input  logic                  resetn,
   result_checker_if.slave       avs,
   output logic [ADDR_WIDTH-1:0] rd_addr_res,
   input  logic [DATA_WIDTH-1:0] q_res,
   output logic [ADDR_WIDTH-1:0] rd_addr_exp,
   input  logic [DATA_WIDTH-1:0] q_exp,
   output logic                  busy
);

   localparam int CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(1) << ADDR_WIDTH;

   rc_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [CNT_W-1:0]      remain_q, remain_d;
   logic [31:0]           err_count_q, err_count_d;
   logic                  err_sat_q, err_sat_d;
   logic                  first_err_valid_q, first_err_valid_d;
   logic [ADDR_WIDTH-1:0] first_err_addr_q, first_err_addr_d;
   logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
   logic [31:0]           readdata_q, readdata_d;

   logic                  wr_ctrl, start_req, clear_req, push, done;
   logic                  pipe_valid;
   logic [ADDR_WIDTH-1:0] pipe_tag;
   logic [31:0]           rdata_mux;

   assign wr_ctrl   = avs.write && (avs.address == REG_CTRL);
   assign clear_req = wr_ctrl && avs.writedata[CTRL_CLEAR];
   assign start_req = wr_ctrl && avs.writedata[CTRL_START] && !avs.writedata[CTRL_CLEAR];
   assign done      = (state_q == ST_DONE);
   assign busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);

   rc_valid_pipe #(
      .DEPTH (RD_LATENCY),
      .TAG_W (ADDR_WIDTH)
   ) u_valid_pipe (
      .clock     (clock),
      .resetn    (resetn),
      .flush     (clear_req),
      .in_valid  (push),
      .in_tag    (rd_addr_q),
      .out_valid (pipe_valid),
      .out_tag   (pipe_tag)
   );

   always_comb begin
      rdata_mux = '0;
      case (avs.address)
         REG_START_ADDR: rdata_mux = 32'(start_addr_q);
         REG_COUNT:      rdata_mux = 32'(count_q);
         REG_STATUS: begin
            rdata_mux[STAT_BUSY]    = busy;
            rdata_mux[STAT_DONE]    = done;
            rdata_mux[STAT_ERR_SAT] = err_sat_q;
         end
         REG_ERR_COUNT:  rdata_mux = err_count_q;
         REG_FIRST_ERR: begin
            rdata_mux                  = 32'(first_err_addr_q);
            rdata_mux[FIRST_ERR_VALID] = first_err_valid_q;
         end
         REG_LAST_ADDR:  rdata_mux = 32'(last_addr_q);
         REG_ID:         rdata_mux = 32'(ID);
         default:        rdata_mux = '0;
      endcase
   end

   always_comb begin
      state_d           = state_q;
      start_addr_d      = start_addr_q;
      count_d           = count_q;
      rd_addr_d         = rd_addr_q;
      remain_d          = remain_q;
      err_count_d       = err_count_q;
      err_sat_d         = err_sat_q;
      first_err_valid_d = first_err_valid_q;
      first_err_addr_d  = first_err_addr_q;
      last_addr_d       = last_addr_q;
      readdata_d        = avs.read ? rdata_mux : readdata_q;
      push              = 1'b0;

      if (avs.write && avs.address == REG_START_ADDR)
         start_addr_d = avs.writedata[ADDR_WIDTH-1:0];
      if (avs.write && avs.address == REG_COUNT)
         count_d = (avs.writedata > 32'(COUNT_MAX)) ? COUNT_MAX : avs.writedata[CNT_W-1:0];

      if (pipe_valid) begin
         last_addr_d = pipe_tag;
         if (q_res != q_exp) begin
            if (err_count_q != ERR_SAT)
               err_count_d = err_count_q + 32'd1;
            if (err_count_q >= ERR_SAT - 32'd1)
               err_sat_d = 1'b1;
            if (!first_err_valid_q) begin
               first_err_valid_d = 1'b1;
               first_err_addr_d  = pipe_tag;
            end
         end
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_req) begin
               err_count_d       = '0;
               err_sat_d         = 1'b0;
               first_err_valid_d = 1'b0;
               first_err_addr_d  = '0;
               rd_addr_d         = start_addr_q;
               remain_d          = count_q;
               state_d           = (count_q == '0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            push      = 1'b1;
            rd_addr_d = rd_addr_q + 1'b1;
            remain_d  = remain_q - 1'b1;
            if (remain_q == CNT_W'(1)) begin
               state_d  = ST_DRAIN;
               remain_d = CNT_W'(RD_LATENCY - 1);
            end
         end
         ST_DRAIN: begin
            if (remain_q == '0)
               state_d = ST_DONE;
            else
               remain_d = remain_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      // CLEAR also beats a compare landing on the same edge
      if (clear_req) begin
         state_d           = ST_IDLE;
         push              = 1'b0;
         err_count_d       = '0;
         err_sat_d         = 1'b0;
         first_err_valid_d = 1'b0;
         first_err_addr_d  = '0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q           <= ST_IDLE;
         start_addr_q      <= '0;
         count_q           <= '0;
         rd_addr_q         <= '0;
         remain_q          <= '0;
         err_count_q       <= '0;
         err_sat_q         <= 1'b0;
         first_err_valid_q <= 1'b0;
         first_err_addr_q  <= '0;
         last_addr_q       <= '0;
         readdata_q        <= '0;
      end else begin
         state_q           <= state_d;
         start_addr_q      <= start_addr_d;
         count_q           <= count_d;
         rd_addr_q         <= rd_addr_d;
         remain_q          <= remain_d;
         err_count_q       <= err_count_d;
         err_sat_q         <= err_sat_d;
         first_err_valid_q <= first_err_valid_d;
         first_err_addr_q  <= first_err_addr_d;
         last_addr_q       <= last_addr_d;
         readdata_q        <= readdata_d;
      end
   end

   assign rd_addr_res  = rd_addr_q;
   assign rd_addr_exp  = rd_addr_q;
   assign avs.readdata = readdata_q;

endmodule

// File: tb/tb_result_checker.sv
module tb_result_checker;
   import result_checker_pkg::*;

   localparam int AW  = 9;
   localparam int DW  = 128;
   localparam int L   = 2;
   localparam int IDV = 9;
   localparam int N   = 512;

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   result_checker_if bus ();
   logic [AW-1:0] rd_addr_res, rd_addr_exp;
   logic [DW-1:0] q_res, q_exp;
   logic          busy;

   result_checker #(.ID(IDV), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .avs         (bus),
      .rd_addr_res (rd_addr_res),
      .q_res       (q_res),
      .rd_addr_exp (rd_addr_exp),
      .q_exp       (q_exp),
      .busy        (busy)
   );

   // RAM models with L cycles from address to q
   logic [DW-1:0] mem_res [N];
   logic [DW-1:0] mem_exp [N];
   logic [AW-1:0] ash_res [L];
   logic [AW-1:0] ash_exp [L];

   always @(posedge clock) begin
      ash_res[0] <= rd_addr_res;
      ash_exp[0] <= rd_addr_exp;
      for (int i = 1; i < L; i++) begin
         ash_res[i] <= ash_res[i-1];
         ash_exp[i] <= ash_exp[i-1];
      end
   end
   assign q_res = mem_res[ash_res[L-1]];
   assign q_exp = mem_exp[ash_exp[L-1]];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // busy-period monitor: counts busy cycles and checks the issued address sequence
   int busy_cycles = 0;
   int addr_bad    = 0;
   int mon_start   = 0;
   int mon_count   = 0;
   always @(negedge clock) begin
      if (resetn && busy === 1'b1) begin
         if (rd_addr_exp !== rd_addr_res) addr_bad++;
         if (busy_cycles < mon_count && rd_addr_res !== AW'((mon_start + busy_cycles) % N))
            addr_bad++;
         busy_cycles++;
      end
   end

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      bus.address   = a;
      bus.writedata = d;
      bus.write     = 1'b1;
      @(negedge clock);
      bus.write     = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      bus.address = a;
      bus.read    = 1'b1;
      @(negedge clock);
      bus.read    = 1'b0;
      d           = bus.readdata;
   endtask

   task automatic restore_exp();
      for (int a = 0; a < N; a++) mem_exp[a] = mem_res[a];
   endtask

   task automatic arm_monitor(input int s, input int c);
      mon_start   = s;
      mon_count   = c;
      busy_cycles = 0;
      addr_bad    = 0;
   endtask

   task automatic start_run(input int s, input int c);
      arm_monitor(s, c);
      bus_write(REG_START_ADDR, 32'(s));
      bus_write(REG_COUNT, 32'(c));
      bus_write(REG_CTRL, 32'h1);
   endtask

   task automatic wait_idle(input string tag);
      int i = 0;
      while (busy === 1'b1 && i < 3000) begin
         @(negedge clock);
         i++;
      end
      check({tag, "_idle_reached"}, 32'(busy), 32'h0);
   endtask

   task automatic check_results(input string tag, input logic [31:0] e_err,
                                input logic [31:0] e_first, input logic [31:0] e_last,
                                input int e_busy);
      logic [31:0] r;
      check({tag, "_busy_cycles"}, busy_cycles, e_busy);
      check({tag, "_issue_addr"}, addr_bad, 0);
      bus_read(REG_STATUS, r);    check({tag, "_status"}, r, 32'h2);
      bus_read(REG_ERR_COUNT, r); check({tag, "_err_count"}, r, e_err);
      bus_read(REG_FIRST_ERR, r); check({tag, "_first_err"}, r, e_first);
      bus_read(REG_LAST_ADDR, r); check({tag, "_last_addr"}, r, e_last);
   endtask

   // reference: walk the window over the two memories
   logic [31:0] model_last = 0;
   task automatic model_run(input int s, input int c, output logic [31:0] e_err,
                            output logic [31:0] e_first);
      int a;
      e_err   = 0;
      e_first = 0;
      for (int i = 0; i < c; i++) begin
         a = (s + i) % N;
         if (mem_res[a] !== mem_exp[a]) begin
            if (e_err == 0) e_first = 32'h8000_0000 | 32'(a);
            e_err++;
         end
      end
      if (c > 0) model_last = 32'((s + c - 1) % N);
   endtask

   typedef struct {
      int          s;
      int          c;
      int          bad0;
      int          bad1;
      logic [31:0] e_err;
      logic [31:0] e_first;
      logic [31:0] e_last;
      int          e_busy;
   } vec_t;

   vec_t vt [6];

   initial begin
      logic [31:0] r, e_err, e_first;
      logic [AW-1:0] ba;
      logic [6:0]    bb;
      int s, c, nbad;

      vt[0] = '{0,   16,  -1, -1,  32'd0, 32'h0,         32'd15,  18};
      vt[1] = '{0,   16,   5,  9,  32'd2, 32'h8000_0005, 32'd15,  18};
      vt[2] = '{510, 4,    0, -1,  32'd1, 32'h8000_0000, 32'd1,   6};
      vt[3] = '{0,   0,   -1, -1,  32'd0, 32'h0,         32'd1,   0};
      vt[4] = '{100, 1,  100, -1,  32'd1, 32'h8000_0064, 32'd100, 3};
      vt[5] = '{511, 512,  3, 511, 32'd2, 32'h8000_01FF, 32'd510, 514};

      bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = '0;
      for (int a = 0; a < N; a++) mem_res[a] = {$urandom, $urandom, $urandom, $urandom};
      restore_exp();

      repeat (3) @(negedge clock);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_rd_addr", 32'(rd_addr_res), 32'h0);
      check("rst_readdata", bus.readdata, 32'h0);
      resetn = 1'b1;
      @(negedge clock);
      bus_read(REG_STATUS, r);    check("rst_status", r, 32'h0);
      bus_read(REG_ERR_COUNT, r); check("rst_err_count", r, 32'h0);
      bus_read(REG_ID, r);        check("id", r, 32'(IDV));
      bus_read(REG_CTRL, r);      check("ctrl_reads_zero", r, 32'h0);

      bus_write(REG_START_ADDR, 32'hFFFF_FE05);
      bus_read(REG_START_ADDR, r); check("start_addr_mask", r, 32'h5);
      bus_write(REG_COUNT, 32'd7);
      bus.address = REG_COUNT; bus.writedata = 32'd9; bus.read = 1'b1; bus.write = 1'b1;
      @(negedge clock);
      bus.read = 1'b0; bus.write = 1'b0;
      check("rw_same_cycle_old", bus.readdata, 32'd7);
      bus_read(REG_COUNT, r); check("rw_same_cycle_new", r, 32'd9);

      for (int v = 0; v < 6; v++) begin
         restore_exp();
         if (vt[v].bad0 >= 0) mem_exp[vt[v].bad0][127] = ~mem_exp[vt[v].bad0][127];
         if (vt[v].bad1 >= 0) mem_exp[vt[v].bad1][127] = ~mem_exp[vt[v].bad1][127];
         start_run(vt[v].s, vt[v].c);
         wait_idle($sformatf("vec%0d", v));
         check_results($sformatf("vec%0d", v), vt[v].e_err, vt[v].e_first, vt[v].e_last, vt[v].e_busy);
         model_last = vt[v].e_last;
      end

      for (int it = 0; it < 10; it++) begin
         restore_exp();
         s    = $urandom_range(0, N - 1);
         c    = $urandom_range(1, 48);
         nbad = $urandom_range(0, 3);
         for (int j = 0; j < nbad; j++) begin
            ba = AW'((s + $urandom_range(0, c - 1)) % N);
            bb = 7'($urandom_range(0, DW - 1));
            mem_exp[ba][bb] = ~mem_exp[ba][bb];
         end
         model_run(s, c, e_err, e_first);
         start_run(s, c);
         wait_idle($sformatf("rnd%0d", it));
         check_results($sformatf("rnd%0d", it), e_err, e_first, model_last, c + L);
      end

      // CLEAR three cycles into a 64-entry run
      restore_exp();
      mem_exp[0][127] = ~mem_exp[0][127];
      mem_exp[1][127] = ~mem_exp[1][127];
      start_run(0, 64);
      repeat (2) @(negedge clock);
      bus_write(REG_CTRL, 32'h2);
      check("clr_busy", 32'(busy), 32'h0);
      bus_read(REG_STATUS, r);    check("clr_status", r, 32'h0);
      bus_read(REG_ERR_COUNT, r); check("clr_err_count", r, 32'h0);
      bus_read(REG_FIRST_ERR, r); check("clr_first_err", r, 32'h0);

      // restart with kept registers; START and new window written while busy
      arm_monitor(0, 64);
      bus_write(REG_CTRL, 32'h1);
      repeat (5) @(negedge clock);
      bus_write(REG_CTRL, 32'h1);
      bus_write(REG_START_ADDR, 32'd200);
      bus_write(REG_COUNT, 32'd5);
      wait_idle("restart");
      check_results("restart", 32'd2, 32'h8000_0000, 32'd63, 64 + L);
      bus_read(REG_START_ADDR, r); check("busy_write_start_addr", r, 32'd200);
      bus_read(REG_COUNT, r);      check("busy_write_count", r, 32'd5);
      restore_exp();
      arm_monitor(200, 5);
      bus_write(REG_CTRL, 32'h1);
      wait_idle("deferred");
      check_results("deferred", 32'd0, 32'h0, 32'd204, 5 + L);

      // reset in the middle of ISSUE
      bus_read(REG_ID, r); check("id_before_reset", r, 32'(IDV));
      start_run(0, 64);
      repeat (3) @(negedge clock);
      resetn = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_rd_addr_res", 32'(rd_addr_res), 32'h0);
      check("mid_rst_rd_addr_exp", 32'(rd_addr_exp), 32'h0);
      check("mid_rst_readdata", bus.readdata, 32'h0);
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      bus_read(REG_STATUS, r);     check("post_rst_status", r, 32'h0);
      bus_read(REG_ERR_COUNT, r);  check("post_rst_err_count", r, 32'h0);
      bus_read(REG_START_ADDR, r); check("post_rst_start_addr", r, 32'h0);
      bus_read(REG_COUNT, r);      check("post_rst_count", r, 32'h0);
      bus_read(REG_ID, r);         check("post_rst_id", r, 32'(IDV));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
